// File: rtl/fx_arb_if.sv
`default_nettype none
// fx_arb_if: request/grant bundle between fx_arb (master) and its four requesters (slave). Rev 1.0
interface fx_arb_if;
  logic [3:0] fx_req;
  logic [3:0] fx_done;
  logic [3:0] fx_gnt;
  logic [1:0] fx_owner;
  logic       fx_busy;
  logic       fx_tout;
  logic [7:0] fx_tout_cnt;

  modport master (
    input  fx_req, fx_done,
    output fx_gnt, fx_owner, fx_busy, fx_tout, fx_tout_cnt
  );

  modport slave (
    output fx_req, fx_done,
    input  fx_gnt, fx_owner, fx_busy, fx_tout, fx_tout_cnt
  );
endinterface
`default_nettype wire

// File: rtl/fx_arb.sv
`default_nettype none
// fx_arb: 4-way round-robin bus arbiter with turnaround gap; grant timeout present when
// FX_ARB_TOUT_EN is defined. Rev 1.0
module fx_arb #(
  parameter int GAP_CYC  = 2,
  parameter int TOUT_MAX = 1023
) (
  input  logic     clk_sys,
  input  logic     rst,
  fx_arb_if.master bus
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic [1:0] last_owner;
  logic       busy;
  logic [3:0] gap_cnt;

  logic [1:0] pick;
  logic [1:0] rr_idx;
  logic       pick_vld;
  logic       gap_last;
  logic       start;
  logic       rel;
  logic       tmo;

  if (GAP_CYC < 1 || GAP_CYC > 15 || TOUT_MAX < 1 || TOUT_MAX > 65535) begin : g_param_check
    $error("fx_arb: GAP_CYC or TOUT_MAX out of range");
  end

  // Descending scan so the requester nearest to last_owner+1 is written last and wins.
  always_comb begin
    pick     = last_owner;
    pick_vld = 1'b0;
    rr_idx   = last_owner;
    for (int k = 3; k >= 0; k--) begin
      rr_idx = last_owner + 2'(k + 1);
      if (bus.fx_req[rr_idx]) begin
        pick     = rr_idx;
        pick_vld = 1'b1;
      end
    end
  end

  assign gap_last = (state == S_GAP) && (gap_cnt == 4'(GAP_CYC - 1));
  // The last gap cycle doubles as the arbitration cycle, so held requests see
  // exactly GAP_CYC idle bus cycles between grants.
  assign start    = pick_vld && ((state == S_IDLE) || gap_last);
  assign rel      = (state == S_GRANT) && (bus.fx_done[owner] || !bus.fx_req[owner]);

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state      <= S_IDLE;
      gnt        <= 4'b0000;
      owner      <= 2'd3;
      last_owner <= 2'd3;
      busy       <= 1'b0;
      gap_cnt    <= 4'd0;
    end else if (start) begin
      state      <= S_GRANT;
      gnt        <= 4'b0001 << pick;
      owner      <= pick;
      last_owner <= pick;
      busy       <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          busy <= 1'b0;
        end
        S_GRANT: begin
          if (rel || tmo) begin
            state   <= S_GAP;
            gnt     <= 4'b0000;
            gap_cnt <= 4'd0;
          end
        end
        S_GAP: begin
          gap_cnt <= gap_cnt + 4'd1;
          if (gap_last) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          gnt   <= 4'b0000;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FX_ARB_TOUT_EN
  logic [15:0] grant_cnt;
  logic        tout;
  logic [7:0]  tout_cnt;

  assign tmo = (state == S_GRANT) && (grant_cnt == 16'(TOUT_MAX - 1));

  // A release by done/req in the same cycle wins over the timeout.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      grant_cnt <= 16'd0;
      tout      <= 1'b0;
      tout_cnt  <= 8'd0;
    end else begin
      tout <= 1'b0;
      if (start) begin
        grant_cnt <= 16'd0;
      end else if (state == S_GRANT) begin
        grant_cnt <= grant_cnt + 16'd1;
      end
      if (tmo && !rel) begin
        tout <= 1'b1;
        if (tout_cnt != 8'hFF) begin
          tout_cnt <= tout_cnt + 8'd1;
        end
      end
    end
  end

  assign bus.fx_tout     = tout;
  assign bus.fx_tout_cnt = tout_cnt;
`else
  assign tmo             = 1'b0;
  assign bus.fx_tout     = 1'b0;
  assign bus.fx_tout_cnt = 8'd0;
`endif

  assign bus.fx_gnt   = gnt;
  assign bus.fx_owner = owner;
  assign bus.fx_busy  = busy;
endmodule
`default_nettype wire

// File: doc/fx_arb.md
FX_ARB -- requirements
Module: fx_arb

Interface
REQ-001 Parameter GAP_CYC, default 2: bus turnaround idle cycles after every release, legal range 1..15.
REQ-002 Parameter TOUT_MAX, default 1023: maximum GRANT cycles before forced release, legal range 1..65535.
REQ-003 clk_sys  in  1  system clock; single clock domain; all logic rising-edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 fx_req  in  4  access requests; bit0=syn, bit1=ad1, bit2=ad2, bit3=ad3.
REQ-006 fx_done  in  4  per-requester end-of-transfer; only the current owner's bit is honoured.
REQ-007 fx_gnt  out  4  one-hot grant; only the granted slave drives a non-zero fx_q onto the shared OR bus.
REQ-008 fx_owner  out  2  encoded index of the current or most recent owner.
REQ-009 fx_busy  out  1  high while in GRANT or GAP.
REQ-010 fx_tout  out  1  one-cycle pulse on a forced timeout release.
REQ-011 fx_tout_cnt  out  8  saturating count of timeouts.

Function
REQ-012 FSM states: IDLE, GRANT, GAP; all outputs registered.
REQ-013 IDLE: if fx_req!=0 at an edge, select a winner by round-robin and enter GRANT, with fx_gnt asserted from the next cycle (latency 1).
REQ-014 Round-robin: the search starts at (last_owner+1) mod 4 and ascends with wrap; last_owner updates on every grant.
REQ-015 fx_gnt SHALL be either zero or one-hot in every cycle; two bits high at once is a failure.
REQ-016 GRANT releases when fx_done[owner]=1 or fx_req[owner]=0; fx_gnt goes to 0 in the following cycle and the FSM enters GAP.
REQ-017 fx_done bits of non-owners are ignored in all states; fx_done in IDLE or GAP is ignored.
REQ-018 GAP holds fx_gnt=0 for exactly GAP_CYC cycles, then goes to IDLE; requests arriving during GAP wait, with none lost or latched.
REQ-019 Arbitration uses fx_req as sampled in the IDLE cycle; requests are level-held by the requesters and there is no request queue.
REQ-020 A GRANT cycle counter (16 bit) clears on GRANT entry and increments each GRANT cycle.
REQ-021 When the GRANT cycle counter reaches TOUT_MAX with no release condition, the same forced release as REQ-016 applies, fx_tout pulses 1 cycle coincident with fx_gnt falling, and fx_tout_cnt increments, saturating at 255.
REQ-022 If done and timeout occur in the same cycle, done has priority: no fx_tout and no count.
REQ-023 fx_busy=1 in GRANT and GAP; fx_busy=0 in IDLE.

Reset
REQ-024 rst=1 at an edge forces IDLE, fx_gnt=0, fx_owner=3, last_owner=3 (first grant searches from 0), fx_busy=0, fx_tout=0, fx_tout_cnt=0, and clears all counters.
REQ-025 rst asserted mid-GRANT drops fx_gnt at the next edge, with no fx_tout pulse; the first grant after reset release follows REQ-013.

Configuration
REQ-026 Macro FX_ARB_TOUT_EN: when defined, the timeout logic of REQ-020..022 is present.
REQ-027 When FX_ARB_TOUT_EN is undefined, the GRANT counter is absent, fx_tout is tied 0, fx_tout_cnt is tied 0, and GRANT ends only via REQ-016; TOUT_MAX is ignored.

Verification
REQ-028 After reset, fx_req=4'b1111 held, each owner pulses done after 5 cycles -> grant order 0,1,2,3,0; each fx_gnt is high 6 cycles, with a 2-cycle zero gap between grants (GAP_CYC=2).
REQ-029 fx_req=4'b0100 only; done at grant cycle 3 -> fx_gnt=4'b0100 one cycle after req, 0 after done, fx_busy low exactly 2 cycles later, fx_tout=0.
REQ-030 With FX_ARB_TOUT_EN and TOUT_MAX=8, fx_req=4'b0010 held, no done -> fx_gnt drops after 8 cycles, fx_tout pulses once, fx_tout_cnt=1; repeated 300 times -> fx_tout_cnt=255.
REQ-031 Owner 1 granted, fx_done=4'b1101 (non-owners only) -> grant persists; then fx_req[1] dropped -> release next cycle, and the next grant goes to 2.
REQ-032 rst pulsed during GRANT of owner 2 -> fx_gnt=0 next edge, fx_tout_cnt=0; fx_req=4'b1111 then grants 0 first.
REQ-033 Done and timeout in the same cycle (TOUT_MAX=4, done on grant cycle 4) -> fx_tout stays 0 and fx_tout_cnt is unchanged.
